// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready payload stream with preamble/SFD,
// zero pad, CRC32 FCS and an enforced inter-frame gap.
module gmii_tx_framer #(
  parameter int N_PREAMBLE = 8,
  parameter int N_IFG      = 12,
  parameter int MIN_FRAME  = 60,
  parameter bit PAD_EN     = 1'b1,
  parameter bit FCS_EN     = 1'b1
) (
  input  logic        gmii_gtx_clk,
  input  logic        sys_rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  underrun_count
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, DROP, IFG} state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  state_t      state;
  logic [7:0]  pre_cnt;
  logic [15:0] ifg_cnt;
  logic [15:0] byte_cnt;
  logic [1:0]  fcs_idx;
  logic [31:0] crc;

  logic [15:0] cnt_inc;
  logic [31:0] fcs_shift;

  // Reflected CRC32 (poly 0x04C11DB7 -> 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign fcs_shift = ~crc >> {fcs_idx, 3'b000};

  assign s_ready = (state == DATA) || (state == DROP);
  assign busy    = (state != IDLE);

  // NOTE: one clocked block with non-blocking assignments only; every pin is
  // a flop, so state decoding never glitches onto the GMII bus.
  always_ff @(posedge gmii_gtx_clk) begin
    if (sys_rst) begin
      state          <= IDLE;
      gmii_txd       <= 8'h00;
      gmii_tx_en     <= 1'b0;
      gmii_tx_er     <= 1'b0;
      pre_cnt        <= 8'd0;
      ifg_cnt        <= 16'd0;
      byte_cnt       <= 16'd0;
      fcs_idx        <= 2'd0;
      crc            <= CRC_INIT;
      frame_count    <= 16'd0;
      underrun_count <= 8'd0;
    end else begin
      gmii_tx_er <= 1'b0;
      case (state)
        IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (s_valid) begin
            state      <= PREAMBLE;
            gmii_txd   <= 8'h55;
            gmii_tx_en <= 1'b1;
            pre_cnt    <= 8'd1;
            byte_cnt   <= 16'd0;
            crc        <= CRC_INIT;
          end
        end

        PREAMBLE: begin
          gmii_tx_en <= 1'b1;
          if (pre_cnt == 8'(N_PREAMBLE - 1)) begin
            gmii_txd <= 8'hD5;
            state    <= DATA;
          end else begin
            gmii_txd <= 8'h55;
            pre_cnt  <= pre_cnt + 8'd1;
          end
        end

        DATA: begin
          gmii_tx_en <= 1'b1;
          if (s_valid) begin
            gmii_txd <= s_data;
            crc      <= crc32_byte(crc, s_data);
            byte_cnt <= cnt_inc;
            if (s_last) begin
              fcs_idx <= 2'd0;
              ifg_cnt <= 16'd0;
              if (PAD_EN && (cnt_inc < 16'(MIN_FRAME))) begin
                state <= PAD;
              end else if (FCS_EN) begin
                state <= FCS;
              end else begin
                state       <= IFG;
                frame_count <= frame_count + 16'd1;
              end
            end
          end else begin
            // Source starved us mid-frame: flag one error cycle, then discard.
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            state      <= DROP;
            if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
          end
        end

        PAD: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b1;
          crc        <= crc32_byte(crc, 8'h00);
          byte_cnt   <= cnt_inc;
          if (cnt_inc >= 16'(MIN_FRAME)) begin
            if (FCS_EN) begin
              state <= FCS;
            end else begin
              state       <= IFG;
              ifg_cnt     <= 16'd0;
              frame_count <= frame_count + 16'd1;
            end
          end
        end

        FCS: begin
          gmii_txd   <= fcs_shift[7:0];
          gmii_tx_en <= 1'b1;
          fcs_idx    <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state       <= IFG;
            ifg_cnt     <= 16'd0;
            frame_count <= frame_count + 16'd1;
          end
        end

        DROP: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (s_valid && s_last) begin
            state   <= IFG;
            ifg_cnt <= 16'd1;
          end
        end

        IFG: begin
          // After a transmitted frame the first IFG cycle still shows the final
          // byte on the wire, so that path starts the count one lower.
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (ifg_cnt >= 16'(N_IFG)) state <= IDLE;
          else ifg_cnt <= ifg_cnt + 16'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: three parameter sets share one stimulus
// stream; per-cycle GMII activity of the selected instance is logged and compared.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;

  logic [2:0] rdy_a, en_a, er_a, busy_a;
  logic [7:0]  txd_a [3];
  logic [15:0] fc_a  [3];
  logic [7:0]  uc_a  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;
  bit drv_timeout;
  bit cap_on   = 1'b0;

  logic [7:0] pl    [$];
  logic [7:0] exp_q [$];
  logic [7:0] log_d [$];
  bit log_en [$];
  bit log_er [$];
  bit log_busy [$];
  bit log_acc [$];

  always #4 clk = ~clk;

  gmii_tx_framer dut_def (
    .gmii_gtx_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(rdy_a[0]), .gmii_txd(txd_a[0]), .gmii_tx_en(en_a[0]),
    .gmii_tx_er(er_a[0]), .busy(busy_a[0]), .frame_count(fc_a[0]), .underrun_count(uc_a[0]));

  gmii_tx_framer #(.PAD_EN(1'b0)) dut_nopad (
    .gmii_gtx_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(rdy_a[1]), .gmii_txd(txd_a[1]), .gmii_tx_en(en_a[1]),
    .gmii_tx_er(er_a[1]), .busy(busy_a[1]), .frame_count(fc_a[1]), .underrun_count(uc_a[1]));

  gmii_tx_framer #(.FCS_EN(1'b0)) dut_nofcs (
    .gmii_gtx_clk(clk), .sys_rst(sys_rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(rdy_a[2]), .gmii_txd(txd_a[2]), .gmii_tx_en(en_a[2]),
    .gmii_tx_er(er_a[2]), .busy(busy_a[2]), .frame_count(fc_a[2]), .underrun_count(uc_a[2]));

  always @(negedge clk) begin
    if (cap_on) begin
      log_d.push_back(txd_a[sel]);
      log_en.push_back(en_a[sel]);
      log_er.push_back(er_a[sel]);
      log_busy.push_back(busy_a[sel]);
      log_acc.push_back(rdy_a[sel] && s_valid);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    sys_rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; drv_timeout = 1'b0;
    repeat (2) @(posedge clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic start_cap();
    log_d = {}; log_en = {}; log_er = {}; log_busy = {}; log_acc = {};
    cap_on = 1'b1;
  endtask

  task automatic stop_cap(input int cycles);
    repeat (cycles) @(posedge clk);
    #1 cap_on = 1'b0;
  endtask

  task automatic set_payload(input int n, input int seed);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'(i * 7 + seed));
  endtask

  // Presents pl[0..n-1]; optional idle gap before byte stall_at, optional reset with byte rst_at.
  task automatic drive_frame(input int n, input int stall_at, input int stall_len,
                             input bit hold, input int rst_at);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit took;
      if (i == stall_at) begin
        s_valid = 1'b0; s_last = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
      end
      s_valid = 1'b1; s_data = pl[i]; s_last = (i == n - 1);
      if (i == rst_at) begin
        sys_rst = 1'b1;
        @(posedge clk);
        #1 sys_rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      took = 1'b0; guard = 0;
      while (!took && guard < 200) begin
        @(negedge clk);
        took = rdy_a[sel];
        @(posedge clk);
        #1;
        guard++;
      end
      if (!took) begin
        drv_timeout = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    if (!hold) begin s_valid = 1'b0; s_last = 1'b0; end
  endtask

  // Expected wire image: preamble, payload, optional pad to 60, optional FCS (bit-serial CRC).
  task automatic build_exp(input int n, input bit pad, input bit fcs);
    logic [7:0]  body [$];
    logic [31:0] c;
    logic [31:0] f;
    exp_q = {};
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) body.push_back(pl[i]);
    if (pad) while (body.size() < 60) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        bit fb;
        fb = c[0] ^ body[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
      exp_q.push_back(body[i]);
    end
    f = ~c;
    if (fcs) for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
  endtask

  function automatic int find_en(input int from);
    for (int i = from; i < log_en.size(); i++) if (log_en[i]) return i;
    return -1;
  endfunction

  function automatic int run_len(input int from);
    int k = 0;
    if (from < 0) return 0;
    while (from + k < log_en.size() && log_en[from + k]) k++;
    return k;
  endfunction

  function automatic int stream_errs(input int from, input int len);
    int e = 0;
    if (from < 0) return len;
    for (int k = 0; k < len; k++) begin
      if (from + k >= log_d.size()) e++;
      else if (log_d[from + k] !== exp_q[k] || !log_en[from + k]) e++;
    end
    return e;
  endfunction

  function automatic int er_total();
    int e = 0;
    foreach (log_er[i]) if (log_er[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    sel = 0;
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (txd_a[d] !== 8'h00) begin n_fail++; $display("FAIL reset_txd[%0d]: got %h want 00", d, txd_a[d]); end
      n_checks++; if (en_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en[%0d]: got %b want 0", d, en_a[d]); end
      n_checks++; if (er_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_tx_er[%0d]: got %b want 0", d, er_a[d]); end
      n_checks++; if (rdy_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready[%0d]: got %b want 0", d, rdy_a[d]); end
      n_checks++; if (busy_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_a[d]); end
      n_checks++; if (fc_a[d] !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count[%0d]: got %0d want 0", d, fc_a[d]); end
      n_checks++; if (uc_a[d] !== 8'd0) begin n_fail++; $display("FAIL reset_underrun_count[%0d]: got %0d want 0", d, uc_a[d]); end
    end
  endtask

  task automatic test_nopad_check_value();
    int s, e, r;
    sel = 1;
    do_reset();
    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    start_cap();
    drive_frame(9, -1, 0, 1'b0, -1);
    stop_cap(30);
    build_exp(9, 1'b0, 1'b0);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    s = find_en(0); e = stream_errs(s, 21); r = run_len(s);
    n_checks++; if (drv_timeout !== 1'b0) begin n_fail++; $display("FAIL nopad_handshake: source stalled, got timeout want none"); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL nopad_stream: %0d wrong bytes, want 0", e); end
    n_checks++; if (r !== 21) begin n_fail++; $display("FAIL nopad_tx_en_len: got %0d want 21", r); end
    n_checks++; if (fc_a[1] !== 16'd1) begin n_fail++; $display("FAIL nopad_frame_count: got %0d want 1", fc_a[1]); end
    n_checks++; if (er_total() !== 0) begin n_fail++; $display("FAIL nopad_tx_er: got %0d cycles want 0", er_total()); end
  endtask

  task automatic test_pad();
    int s, e, r;
    sel = 0;
    do_reset();
    pl = {8'hAB};
    start_cap();
    drive_frame(1, -1, 0, 1'b0, -1);
    stop_cap(90);
    build_exp(1, 1'b1, 1'b1);
    s = find_en(0); e = stream_errs(s, 72); r = run_len(s);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL pad_stream: %0d wrong bytes, want 0", e); end
    n_checks++; if (r !== 72) begin n_fail++; $display("FAIL pad_tx_en_len: got %0d want 72", r); end
    n_checks++; if (fc_a[0] !== 16'd1) begin n_fail++; $display("FAIL pad_frame_count: got %0d want 1", fc_a[0]); end
  endtask

  task automatic test_back_to_back();
    int s1, r1, s2, r2, e1, e2;
    sel = 0;
    do_reset();
    set_payload(64, 3);
    start_cap();
    drive_frame(64, -1, 0, 1'b1, -1);
    drive_frame(64, -1, 0, 1'b0, -1);
    stop_cap(30);
    build_exp(64, 1'b1, 1'b1);
    s1 = find_en(0); r1 = run_len(s1);
    s2 = find_en(s1 + r1); r2 = run_len(s2);
    e1 = stream_errs(s1, 76); e2 = stream_errs(s2, 76);
    n_checks++; if (drv_timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_handshake: source stalled, got timeout want none"); end
    n_checks++; if (r1 !== 76 || r2 !== 76) begin n_fail++; $display("FAIL b2b_tx_en_len: got %0d/%0d want 76/76", r1, r2); end
    n_checks++; if (s2 - (s1 + r1) !== 13 || s2 < 0) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles want 13", s2 - (s1 + r1)); end
    n_checks++; if (e1 !== 0 || e2 !== 0) begin n_fail++; $display("FAIL b2b_stream: %0d/%0d wrong bytes, want 0/0", e1, e2); end
    n_checks++; if (fc_a[0] !== 16'd2) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want 2", fc_a[0]); end
  endtask

  task automatic test_underrun();
    int s, r, e, acc, last_acc, ifg;
    sel = 0;
    do_reset();
    set_payload(100, 11);
    start_cap();
    drive_frame(100, 10, 3, 1'b0, -1);
    stop_cap(30);
    build_exp(100, 1'b1, 1'b1);
    s = find_en(0); r = run_len(s); e = stream_errs(s, 18);
    acc = 0; last_acc = -1;
    foreach (log_acc[i]) if (log_acc[i]) begin acc++; last_acc = i; end
    ifg = 0;
    while (last_acc >= 0 && last_acc + 1 + ifg < log_busy.size() && log_busy[last_acc + 1 + ifg]) ifg++;
    n_checks++; if (drv_timeout !== 1'b0) begin n_fail++; $display("FAIL underrun_handshake: source stalled, got timeout want none"); end
    n_checks++; if (r !== 19) begin n_fail++; $display("FAIL underrun_tx_en_len: got %0d want 19", r); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL underrun_stream: %0d wrong bytes, want 0", e); end
    n_checks++; if (s < 0 || log_er[s + 18] !== 1'b1 || log_d[s + 18] !== 8'h00) begin n_fail++; $display("FAIL underrun_err_cycle: er/txd wrong at error slot, want 1/00"); end
    n_checks++; if (er_total() !== 1) begin n_fail++; $display("FAIL underrun_er_count: got %0d cycles want 1", er_total()); end
    n_checks++; if (find_en(s + 19) !== -1) begin n_fail++; $display("FAIL underrun_drop_silent: tx_en seen at %0d, want none", find_en(s + 19)); end
    n_checks++; if (acc !== 100) begin n_fail++; $display("FAIL underrun_consumed: got %0d bytes want 100", acc); end
    n_checks++; if (ifg !== 12) begin n_fail++; $display("FAIL underrun_ifg: got %0d busy cycles want 12", ifg); end
    n_checks++; if (uc_a[0] !== 8'd1) begin n_fail++; $display("FAIL underrun_count: got %0d want 1", uc_a[0]); end
    n_checks++; if (fc_a[0] !== 16'd0) begin n_fail++; $display("FAIL underrun_frame_count: got %0d want 0", fc_a[0]); end
  endtask

  task automatic test_no_fcs();
    int s, r, e;
    sel = 2;
    do_reset();
    set_payload(70, 5);
    start_cap();
    drive_frame(70, -1, 0, 1'b0, -1);
    stop_cap(30);
    build_exp(70, 1'b1, 1'b0);
    s = find_en(0); r = run_len(s); e = stream_errs(s, 78);
    n_checks++; if (r !== 78) begin n_fail++; $display("FAIL nofcs_tx_en_len: got %0d want 78", r); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL nofcs_stream: %0d wrong bytes, want 0", e); end
    n_checks++; if (fc_a[2] !== 16'd1) begin n_fail++; $display("FAIL nofcs_frame_count: got %0d want 1", fc_a[2]); end
  endtask

  task automatic test_reset_midframe();
    int s, r, e;
    sel = 0;
    do_reset();
    set_payload(40, 1);
    start_cap();
    drive_frame(40, -1, 0, 1'b0, 19);
    @(negedge clk);
    n_checks++; if (txd_a[0] !== 8'h00) begin n_fail++; $display("FAIL midrst_txd: got %h want 00", txd_a[0]); end
    n_checks++; if (en_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_en: got %b want 0", en_a[0]); end
    n_checks++; if (er_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_er: got %b want 0", er_a[0]); end
    n_checks++; if (rdy_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_s_ready: got %b want 0", rdy_a[0]); end
    n_checks++; if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_a[0]); end
    n_checks++; if (fc_a[0] !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_count: got %0d want 0", fc_a[0]); end
    cap_on = 1'b0;
    @(posedge clk);
    #1;
    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    start_cap();
    drive_frame(9, -1, 0, 1'b0, -1);
    stop_cap(90);
    build_exp(9, 1'b1, 1'b1);
    s = find_en(0); r = run_len(s); e = stream_errs(s, 72);
    n_checks++; if (r !== 72) begin n_fail++; $display("FAIL midrst_next_len: got %0d want 72", r); end
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL midrst_next_stream: %0d wrong bytes, want 0", e); end
    n_checks++; if (fc_a[0] !== 16'd1) begin n_fail++; $display("FAIL midrst_next_frame_count: got %0d want 1", fc_a[0]); end
  endtask

  initial begin
    sys_rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; drv_timeout = 1'b0;
    test_reset();
    test_nopad_check_value();
    test_pad();
    test_back_to_back();
    test_underrun();
    test_no_fcs();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Synthesizable GMII transmit framer; the RTL successor of the bench-side preamble/byte/IFG drivers.
- Takes payload bytes on a valid/ready stream and drives gmii_txd/gmii_tx_en: preamble+SFD, payload, zero pad to minimum length, Ethernet FCS, then enforced inter-frame gap.
- Sits between the frame buffer and the GMII TX pins, in the gmii_gtx_clk domain.

Parameters:
N_PREAMBLE, 8, bytes of preamble including SFD (>=2); N_PREAMBLE-1 x 0x55 then 0xD5
N_IFG, 12, idle cycles enforced after the last frame byte (>=1)
MIN_FRAME, 60, minimum payload+pad byte count before FCS
PAD_EN, 1, 1 = zero-pad short frames to MIN_FRAME
FCS_EN, 1, 1 = append 4-byte CRC32 FCS

Ports:
gmii_gtx_clk  in  1  125 MHz clock; all logic on its rising edge
sys_rst  in  1  synchronous reset, active-high
s_data  in  8  payload byte
s_valid  in  1  s_data valid
s_last  in  1  marks final payload byte of a frame
s_ready  out  1  byte accepted when s_valid && s_ready
gmii_txd  out  8  GMII transmit data, registered
gmii_tx_en  out  1  GMII transmit enable, registered
gmii_tx_er  out  1  GMII transmit error, registered
busy  out  1  high in every state except IDLE
frame_count  out  16  completed frames, wraps at 2^16
underrun_count  out  8  aborted frames, saturates at 255

Behaviour:
- Reset (sys_rst=1 at a clock edge): next cycle gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, s_ready=0, busy=0, both counters=0, state=IDLE. Applies mid-frame: frame truncated, no FCS, no error cycle, no count.
- States: IDLE, PREAMBLE, DATA, PAD, FCS, DROP, IFG.
- IDLE: outputs 0. s_valid=1 at edge t -> PREAMBLE; first 0x55 on gmii_txd at t+1 with gmii_tx_en=1. s_ready=0 in IDLE (the byte is not consumed yet).
- PREAMBLE: N_PREAMBLE cycles; last one drives 0xD5.
- DATA: s_ready=1 exactly in the cycles that consume payload; the byte accepted at edge k appears on gmii_txd at k+1. First payload byte follows SFD with no gap; tx_en stays 1 continuously.
- Byte counter (16-bit, saturating) counts payload+pad bytes.
- On accepting s_last: PAD if PAD_EN && count<MIN_FRAME, else FCS if FCS_EN, else IFG.
- PAD: drive 0x00 until count==MIN_FRAME, then FCS or IFG.
- FCS: CRC32 reflected, poly 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, over payload+pad. Sent as 4 bytes, least-significant byte first. CRC register updates in the same cycle each byte is driven.
- frame_count increments once when the last byte (FCS or last data/pad byte) is driven.
- Underrun: in DATA with s_ready=1 and s_valid=0 -> next cycle gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00. Then DROP. underrun_count++ (saturate). frame_count unchanged.
- DROP: tx_en=0, s_ready=1; discard bytes up to and including s_valid&&s_last, then IFG. Underrun is detected only in DATA; stalls in DROP are harmless.
- IFG: N_IFG cycles of txd=0, tx_en=0, s_ready=0, then IDLE.
- Back-to-back timing: last frame byte at cycle t -> next preamble first byte no earlier than t+N_IFG+2 (N_IFG gap cycles plus the IDLE sampling cycle). Exactly t+N_IFG+2 when s_valid is already high.
- gmii_tx_er=0 except the single underrun cycle.
- busy=0 only in IDLE.

Test Plan:
- PAD_EN=0, payload ASCII "123456789" -> 8 preamble bytes (7x55, D5), 9 data bytes, FCS 26 39 F4 CB; tx_en high 21 contiguous cycles; frame_count=1.
- Defaults, 1-byte payload 0xAB -> 8 preamble, AB, 59x 00, 4 FCS bytes matching a reference CRC model; tx_en high 72 cycles.
- Two back-to-back 64-byte frames, s_valid always high -> exactly N_IFG+1=13 cycles of tx_en=0 between frames; frame_count=2.
- Underrun: s_valid dropped after 10th payload byte of a 100-byte frame -> one cycle tx_en=1/tx_er=1/txd=00, remaining 90 bytes consumed with tx_en=0, then 12 IFG cycles; underrun_count=1, frame_count=0.
- FCS_EN=0, PAD_EN=1, 70-byte payload -> 8+70 tx_en cycles, no pad, no FCS.
- sys_rst pulsed during 20th payload byte -> next cycle all outputs 0, busy=0; a following fresh frame transmits correctly with frame_count=1.
